branch_target_predictor: RTL and testbench

Parametrised direct-mapped branch target buffer with 2-bit saturating counters for the pipelined MIPS core. It sits beside the IF-stage PC register and gives a predicted next PC every cycle. It is trained from branch/jump resolution in the MEM stage, replacing the fixed predict-not-taken behaviour. It also flags mispredictions and supplies the corrected PC, which the hazard unit uses to flush IF/ID, ID/EX and EX/MEM.

---
 rtl/branch_target_predictor.sv | 91 +++++++++
 tb/tb_branch_target_predictor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with 2-bit counters, combinational lookup and resolution
// Define BP_PERF_EN to add perf_branches / perf_mispredicts counters.
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc_if,
    output logic        pred_taken,
    output logic [31:0] pred_next_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_jump,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_next_pc,
    input  logic        flush_all,
    output logic        mispredict,
    output logic [31:0] correct_pc
`ifdef BP_PERF_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
`endif
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW = 30 - IDX;
    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] jmp;
    logic [TW-1:0] tag [ENTRIES];
    logic [31:0] target [ENTRIES];
    logic [1:0] ctr [ENTRIES];
    logic [IDX-1:0] li, ui;
    logic hit, uhit;
    logic unused;
    assign unused = upd_pred_taken;
    assign li = pc_if[IDX+1:2];
    assign ui = upd_pc[IDX+1:2];
    assign hit = valid[li] && tag[li] == pc_if[31:IDX+2];
    assign uhit = valid[ui] && tag[ui] == upd_pc[31:IDX+2];
    assign pred_taken = hit && (jmp[li] || ctr[li][1]);
    assign pred_next_pc = pred_taken ? target[li] : pc_if + 32'd4;
    assign correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;
    assign mispredict = upd_valid && correct_pc != upd_pred_next_pc;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
            jmp <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i] <= '0;
                target[i] <= '0;
                ctr[i] <= CTR_INIT;
            end
        end else if (flush_all) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
        end else if (upd_valid) begin
            if (uhit) begin
                if (upd_is_jump) begin
                    ctr[ui] <= 2'b11;
                    jmp[ui] <= 1'b1;
                    target[ui] <= upd_target;
                end else if (upd_taken) begin
                    ctr[ui] <= ctr[ui] == 2'b11 ? 2'b11 : ctr[ui] + 2'd1;
                    target[ui] <= upd_target;
                end else begin
                    ctr[ui] <= ctr[ui] == 2'b00 ? 2'b00 : ctr[ui] - 2'd1;
                end
            end else if (upd_taken) begin
                valid[ui] <= 1'b1;
                tag[ui] <= upd_pc[31:IDX+2];
                target[ui] <= upd_target;
                jmp[ui] <= upd_is_jump;
                ctr[ui] <= upd_is_jump ? 2'b11 : 2'b10;
            end
        end
    end
`ifdef BP_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_branches <= '0;
            perf_mispredicts <= '0;
        end else begin
            perf_branches <= perf_branches + {31'd0, upd_valid};
            perf_mispredicts <= perf_mispredicts + {31'd0, mispredict};
        end
    end
`endif
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed vectors with a cycle-tagged scoreboard and negedge monitor
module tb_branch_target_predictor;
    logic CLK = 0, nRST = 0;
    logic [31:0] pc_if = 0, upd_pc = 0, upd_target = 0, upd_pred_next_pc = 0;
    logic upd_valid = 0, upd_is_jump = 0, upd_taken = 0, upd_pred_taken = 0, flush_all = 0;
    logic pred_taken, mispredict;
    logic [31:0] pred_next_pc, correct_pc;
`ifdef BP_PERF_EN
    logic [31:0] perf_branches, perf_mispredicts;
`endif
    typedef struct {
        int cyc;
        int kind;
        logic [31:0] exp;
        string name;
    } exp_t;
    exp_t q[$];
    int cyc = 0, tests = 0, fails = 0;

    branch_target_predictor #(.ENTRIES(16), .CTR_INIT(2'b01)) dut (
        .CLK(CLK), .nRST(nRST), .pc_if(pc_if), .pred_taken(pred_taken),
        .pred_next_pc(pred_next_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_next_pc(upd_pred_next_pc),
        .flush_all(flush_all), .mispredict(mispredict), .correct_pc(correct_pc)
`ifdef BP_PERF_EN
        , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int kind);
        logic [31:0] v;
        v = 'x;
        case (kind)
            0: v = {31'd0, pred_taken};
            1: v = pred_next_pc;
            2: v = {31'd0, mispredict};
            3: v = correct_pc;
`ifdef BP_PERF_EN
            4: v = perf_branches;
            5: v = perf_mispredicts;
`endif
            default: v = 'x;
        endcase
        return v;
    endfunction

    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.kind);
            tests++;
            if (e.cyc != cyc) begin
                fails++;
                $display("FAIL %s: check missed its cycle %0d (now %0d)", e.name, e.cyc, cyc);
            end else if (a !== e.exp) begin
                fails++;
                $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, a, e.exp, cyc);
            end
        end
    end

    task automatic step(input logic rst_n, input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                        input logic j, input logic t, input logic [31:0] tgt, input logic [31:0] ppn,
                        input logic fl);
        @(posedge CLK);
        #1;
        nRST = rst_n;
        pc_if = pc;
        upd_valid = uv;
        upd_pc = upc;
        upd_is_jump = j;
        upd_taken = t;
        upd_target = tgt;
        upd_pred_next_pc = ppn;
        upd_pred_taken = ppn != upc + 32'd4;
        flush_all = fl;
    endtask

    task automatic ex(input int kind, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc = cyc;
        e.kind = kind;
        e.exp = v;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic ex_pred(input logic t, input logic [31:0] n, input string name);
        ex(0, {31'd0, t}, {name, "_taken"});
        ex(1, n, {name, "_next"});
    endtask

    task automatic ex_res(input logic m, input logic [31:0] c, input string name);
        ex(2, {31'd0, m}, {name, "_mis"});
        ex(3, c, {name, "_cpc"});
    endtask

    task automatic ex_perf(input logic [31:0] b, input logic [31:0] m, input string name);
`ifdef BP_PERF_EN
        ex(4, b, {name, "_branches"});
        ex(5, m, {name, "_mispredicts"});
`else
        if (b === 32'hx || m === 32'hx) $display("perf %s skipped", name);
`endif
    endtask

    initial begin
        step(0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        ex_pred(0, 32'h44, "reset_lookup");
        ex_res(0, 32'h4, "reset_res");
        ex_perf(0, 0, "reset_perf");
        step(1, 32'h40, 1, 32'h40, 0, 1, 32'h100, 32'h44, 0);
        ex_pred(0, 32'h44, "alloc_prelookup");
        ex_res(1, 32'h100, "alloc_res");
        step(1, 32'h40, 1, 32'h40, 0, 0, 0, 32'h100, 0);
        ex_pred(1, 32'h100, "ctr10_lookup");
        ex_res(1, 32'h44, "nt1_res");
        step(1, 32'h40, 1, 32'h40, 0, 0, 0, 32'h44, 0);
        ex_pred(0, 32'h44, "ctr01_lookup");
        ex_res(0, 32'h44, "nt2_res");
        step(1, 32'h40, 1, 32'h40, 0, 1, 32'h100, 32'h44, 0);
        ex_pred(0, 32'h44, "ctr00_lookup");
        ex_res(1, 32'h100, "retake_res");
        step(1, 32'h40, 1, 32'h440, 0, 1, 32'h200, 32'h444, 0);
        ex_pred(0, 32'h44, "ctr01_again");
        ex_res(1, 32'h200, "alias_res");
        step(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        ex_pred(0, 32'h44, "alias_evicted");
        step(1, 32'h440, 0, 0, 0, 0, 0, 0, 0);
        ex_pred(1, 32'h200, "alias_hit");
        step(1, 32'h80, 1, 32'h80, 1, 1, 32'h300, 32'h84, 0);
        ex_pred(0, 32'h84, "jr_prelookup");
        ex_res(1, 32'h300, "jr1_res");
        step(1, 32'h80, 1, 32'h80, 1, 1, 32'h304, 32'h300, 0);
        ex_pred(1, 32'h300, "jr_lookup");
        ex_res(1, 32'h304, "jr2_res");
        step(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        ex_pred(1, 32'h304, "jr_retarget");
        step(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
        ex_pred(0, 32'h0, "pc_wrap");
        step(1, 32'h60, 1, 32'h60, 0, 1, 32'h500, 32'h64, 1);
        ex_pred(0, 32'h64, "flush_prelookup");
        ex_res(1, 32'h500, "flush_res");
        step(1, 32'h60, 0, 0, 0, 0, 0, 0, 0);
        ex_pred(0, 32'h64, "flush_dropped_upd");
        step(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        ex_pred(0, 32'h84, "flush_jr_gone");
        step(1, 32'h440, 0, 0, 0, 0, 0, 0, 0);
        ex_pred(0, 32'h444, "flush_alias_gone");
        ex_perf(8, 7, "perf_run1");
        step(0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        ex_perf(0, 0, "perf_reset1");
        step(1, 32'h40, 1, 32'h40, 0, 1, 32'h100, 32'h44, 0);
        ex_res(1, 32'h100, "p1_res");
        step(1, 32'h40, 1, 32'h40, 0, 1, 32'h100, 32'h100, 0);
        ex_pred(1, 32'h100, "p2_lookup");
        ex_res(0, 32'h100, "p2_res");
        step(1, 32'h40, 1, 32'h40, 0, 0, 0, 32'h100, 0);
        ex_pred(1, 32'h100, "ctr11_lookup");
        ex_res(1, 32'h44, "p3_res");
        step(1, 32'h40, 1, 32'h40, 0, 1, 32'h100, 32'h100, 0);
        ex_pred(1, 32'h100, "ctr10_again");
        ex_res(0, 32'h100, "p4_res");
        step(1, 32'h44, 1, 32'h44, 0, 0, 0, 32'h48, 0);
        ex_res(0, 32'h48, "p5_res");
        step(1, 32'h44, 0, 0, 0, 0, 0, 0, 0);
        ex_pred(0, 32'h48, "nt_miss_no_alloc");
        ex_perf(5, 2, "perf_run2");
        step(0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        ex_pred(0, 32'h44, "midreset_lookup");
        ex_perf(0, 0, "perf_reset2");
        step(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        ex_pred(0, 32'h44, "post_reset_empty");
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
        @(posedge CLK);
        if (q.size() > 0) begin
            fails++;
            tests++;
            $display("FAIL drain: %0d checks left unserviced, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
